// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side and SRAM-side signal bundle for the MEM stage SRAM controller.
// ready high = the stage may advance this cycle; ready low = upstream freezes and holds its inputs stable.
interface mem_stage_sram_ctrl_if;
  logic        WB_EN_In;
  logic        MEM_R_EN_In;
  logic        MEM_W_EN_In;
  logic [3:0]  Dest_In;
  logic [31:0] ALU_Res_In;
  logic [31:0] Val_Rm_In;

  logic        WB_EN_Out;
  logic        MEM_R_EN_Out;
  logic [3:0]  Dest_Out;
  logic [31:0] ALU_Res_Out;
  logic [31:0] Mem_Data_Out;
  logic        ready;

  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DQ_Out;
  logic        SRAM_DQ_OE;
  logic [15:0] SRAM_DQ_In;

  modport slave (
    input  WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, Dest_In, ALU_Res_In, Val_Rm_In, SRAM_DQ_In,
    output WB_EN_Out, MEM_R_EN_Out, Dest_Out, ALU_Res_Out, Mem_Data_Out, ready,
           SRAM_ADDR, SRAM_WE_N, SRAM_DQ_Out, SRAM_DQ_OE
  );

  modport master (
    output WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, Dest_In, ALU_Res_In, Val_Rm_In, SRAM_DQ_In,
    input  WB_EN_Out, MEM_R_EN_Out, Dest_Out, ALU_Res_Out, Mem_Data_Out, ready,
           SRAM_ADDR, SRAM_WE_N, SRAM_DQ_Out, SRAM_DQ_OE
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage controller: splits each 32-bit load/store into two 16-bit SRAM half-accesses
// and stalls the pipeline until the word is complete.
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  mem_stage_sram_ctrl_if.slave        bus,
  output logic [1:0]                  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0] BASE = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req, is_write, is_read, last_cyc;
  logic [16:0] word_addr;
  logic [12:0] addr_hi_unused;
  logic [1:0]  addr_lo_unused;
  logic [31:0] mem_data;

  logic        ready_c;
  logic [17:0] sram_addr_c;
  logic        we_n_c;
  logic        oe_c;
  logic [15:0] dq_out_c;

  assign req      = bus.MEM_R_EN_In | bus.MEM_W_EN_In;
  assign is_write = bus.MEM_W_EN_In;
  assign is_read  = bus.MEM_R_EN_In & ~bus.MEM_W_EN_In;
  assign last_cyc = ((state == LO) || (state == HI)) && (cnt == LAST);

  // Word index wraps modulo 2^17; byte offset and high bits are dropped.
  assign {addr_hi_unused, word_addr, addr_lo_unused} = bus.ALU_Res_In - BASE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready_c     = 1'b0;
    sram_addr_c = 18'd0;
    we_n_c      = 1'b1;
    oe_c        = 1'b0;
    dq_out_c    = 16'd0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = 4'd0;
        end else begin
          ready_c = 1'b1;
        end
      end
      LO: begin
        sram_addr_c = {word_addr, 1'b0};
        if (is_write) begin
          we_n_c   = 1'b0;
          oe_c     = 1'b1;
          dq_out_c = bus.Val_Rm_In[15:0];
        end
        if (cnt == LAST) begin
          state_nxt = HI;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HI: begin
        sram_addr_c = {word_addr, 1'b1};
        if (is_write) begin
          we_n_c   = 1'b0;
          oe_c     = 1'b1;
          dq_out_c = bus.Val_Rm_In[31:16];
        end
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        ready_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Each half of a load is captured on the final cycle its address is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= 32'd0;
    end else if (is_read && last_cyc) begin
      if (state == LO) mem_data[15:0]  <= bus.SRAM_DQ_In;
      else             mem_data[31:16] <= bus.SRAM_DQ_In;
    end
  end

  assign bus.ready        = ready_c;
  assign bus.WB_EN_Out    = bus.WB_EN_In & ready_c;
  assign bus.MEM_R_EN_Out = bus.MEM_R_EN_In & ready_c;
  assign bus.Dest_Out     = bus.Dest_In;
  assign bus.ALU_Res_Out  = bus.ALU_Res_In;
  assign bus.Mem_Data_Out = mem_data;
  assign bus.SRAM_ADDR    = sram_addr_c;
  assign bus.SRAM_WE_N    = we_n_c;
  assign bus.SRAM_DQ_OE   = oe_c;
  assign bus.SRAM_DQ_Out  = dq_out_c;
  assign dbg_state        = state;
endmodule

// File: doc/mem_stage_sram_ctrl.md
MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

Interface
REQ-001 Parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-002 Parameter ACCESS_CYCLES, default 2, cycles each 16-bit half-access is held on the SRAM pins; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 WB_EN_In, MEM_R_EN_In, MEM_W_EN_In  in  1 each  control from EXE/MEM register.
REQ-006 Dest_In  in  4  destination register; ALU_Res_In  in  32  byte address / ALU result; Val_Rm_In  in  32  store data.
REQ-007 WB_EN_Out, MEM_R_EN_Out  out  1 each  control to MEM/WB register.
REQ-008 Dest_Out  out  4; ALU_Res_Out  out  32; Mem_Data_Out  out  32  loaded word.
REQ-009 ready  out  1  high = stage may advance; low = freeze PC and all upstream pipeline registers.
REQ-010 SRAM_ADDR  out  18; SRAM_WE_N  out  1  active-low write; SRAM_DQ_Out  out  16; SRAM_DQ_OE  out  1  drive-enable for the data bus; SRAM_DQ_In  in  16.

Function
REQ-011 States: IDLE, LO, HI, DONE; a cycle counter of 4 bits tracks cycles spent in LO/HI.
REQ-012 Request = MEM_R_EN_In | MEM_W_EN_In; when both are high the access is a write.
REQ-013 IDLE: no request -> stay, ready=1; request -> LO next cycle, counter cleared, ready=0 this cycle.
REQ-014 LO: held ACCESS_CYCLES cycles, then HI with counter cleared; HI: held ACCESS_CYCLES cycles, then DONE.
REQ-015 DONE: ready=1 for exactly one cycle, then IDLE unconditionally; a request present in the following IDLE cycle is a new access.
REQ-016 ready = 1 in IDLE without request and in DONE; 0 otherwise; combinational from state and request inputs.
REQ-017 Per access ready is low for 2*ACCESS_CYCLES+1 consecutive cycles (5 at default), high in the next.
REQ-018 Word address W = (ALU_Res_In - ADDR_BASE) >> 2, 32-bit subtraction, low 17 bits kept, upper bits discarded (wrap).
REQ-019 SRAM_ADDR = {W,1'b0} in LO, {W,1'b1} in HI, 0 in IDLE and DONE.
REQ-020 Writes: SRAM_WE_N=0 and SRAM_DQ_OE=1 every LO/HI cycle; SRAM_DQ_Out = Val_Rm_In[15:0] in LO, Val_Rm_In[31:16] in HI.
REQ-021 Reads, IDLE, DONE: SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_DQ_Out=0.
REQ-022 Reads: SRAM_DQ_In sampled into Mem_Data_Out[15:0] on the last LO cycle and into [31:16] on the last HI cycle.
REQ-023 Mem_Data_Out is registered, holds its value between loads and is unchanged by writes.
REQ-024 WB_EN_Out = WB_EN_In & ready; MEM_R_EN_Out = MEM_R_EN_In & ready; stalled cycles present a bubble downstream.
REQ-025 Dest_Out = Dest_In and ALU_Res_Out = ALU_Res_In, combinational pass-through.
REQ-026 Upstream inputs are held stable by the freeze while ready=0; the block does not latch them.

Reset
REQ-027 rst high forces, without waiting for a clock edge: state IDLE, counter 0, Mem_Data_Out 0, SRAM_WE_N 1, SRAM_DQ_OE 0, SRAM_ADDR 0.
REQ-028 Reset during LO or HI aborts the access; no further SRAM write strobe is issued; after release the block is in IDLE.

Verification
REQ-029 Load: ALU_Res_In=1032, MEM_R_EN_In=1, SRAM returns 0x5678 at addr 4 and 0x1234 at addr 5 -> ready low 5 cycles, Mem_Data_Out=0x12345678 in the DONE cycle.
REQ-030 Store: ALU_Res_In=1024, MEM_W_EN_In=1, Val_Rm_In=0xDEADBEEF -> WE_N low 2 cycles at addr 0 with 0xBEEF, 2 cycles at addr 1 with 0xDEAD; Mem_Data_Out unchanged.
REQ-031 No request: ALU instruction with WB_EN_In=1 -> ready=1, WB_EN_Out=1 every cycle, WE_N=1 throughout.
REQ-032 Back-to-back load then store -> DONE of the load followed by IDLE, then a full store sequence; WB_EN_Out high only in the load's DONE cycle.
REQ-033 Reset asserted during the second LO cycle of a store -> outputs at reset values immediately, no HI write, ready=1 in IDLE after release.
REQ-034 ACCESS_CYCLES=1 and ALU_Res_In=1020 (wrap) -> ready low 3 cycles, SRAM_ADDR = 0x3FFFE then 0x3FFFF.
